// File: rtl/tg_pulse_gen_if.sv
// Handshake/bus bundle for the pulse generator.
// master: the requester, which drives start/width/gap/count and observes the status lines.
// slave : the generator, which drives pulse_out/busy/done/err_zero_width.
interface tg_pulse_gen_if #(parameter int CNT_W = 4) ();
  logic             start;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] gap;
  logic [CNT_W-1:0] count;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             err_zero_width;

  modport master (output start, width, gap, count,
                  input  pulse_out, busy, done, err_zero_width);
  modport slave  (input  start, width, gap, count,
                  output pulse_out, busy, done, err_zero_width);
endinterface

// File: rtl/tg_pulse_gen.sv
// Pulse-train generator for the DA_test lines.
// A start request in IDLE starts a train of `count` high pulses. Each pulse is `width`
// cycles long, and consecutive pulses are separated by `gap` low cycles.
// Ports:
//   clk   - clock, posedge
//   C_rst - synchronous active-high reset
//   bus   - slave side of tg_pulse_gen_if:
//           start/width/gap/count in; pulse_out/busy/done/err_zero_width out (all registered)
module tg_pulse_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             C_rst,
  tg_pulse_gen_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] w_sh, w_sh_nx;    // latched width, reloaded at every HIGH entry
  logic [CNT_W-1:0] g_sh, g_sh_nx;    // latched gap, already forced to at least 1
  logic [CNT_W-1:0] w_cnt, w_cnt_nx;
  logic [CNT_W-1:0] g_cnt, g_cnt_nx;
  logic [CNT_W-1:0] p_cnt, p_cnt_nx;  // pulses remaining, including the current one
  logic             pulse_q, pulse_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             err_q, err_nx;

  always_ff @(posedge clk) begin
    if (C_rst) begin
      state   <= IDLE;
      w_sh    <= '0;
      g_sh    <= '0;
      w_cnt   <= '0;
      g_cnt   <= '0;
      p_cnt   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      w_sh    <= w_sh_nx;
      g_sh    <= g_sh_nx;
      w_cnt   <= w_cnt_nx;
      g_cnt   <= g_cnt_nx;
      p_cnt   <= p_cnt_nx;
      pulse_q <= pulse_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
    end
  end

  // The next-state logic computes the next value of every output as well, so each output
  // leaves a flop and no input reaches an output combinationally.
  always_comb begin
    state_nx = state;
    w_sh_nx  = w_sh;
    g_sh_nx  = g_sh;
    w_cnt_nx = w_cnt;
    g_cnt_nx = g_cnt;
    p_cnt_nx = p_cnt;
    pulse_nx = pulse_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        pulse_nx = 1'b0;
        busy_nx  = 1'b0;
        if (bus.start) begin
          if (bus.width != '0) begin
            w_sh_nx  = bus.width;
            g_sh_nx  = (bus.gap == '0) ? ONE : bus.gap;
            p_cnt_nx = (bus.count == '0) ? ONE : bus.count;
            w_cnt_nx = bus.width;
            pulse_nx = 1'b1;
            busy_nx  = 1'b1;
            state_nx = HIGH;
          end else begin
            // A zero-width pulse could never satisfy the downstream checker, so the
            // request is refused and flagged instead.
            err_nx = 1'b1;
          end
        end
      end
      HIGH: begin
        if (w_cnt <= ONE) begin
          pulse_nx = 1'b0;
          p_cnt_nx = p_cnt - ONE;
          if (p_cnt <= ONE) begin
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            g_cnt_nx = g_sh;
            state_nx = GAP;
          end
        end else begin
          w_cnt_nx = w_cnt - ONE;
        end
      end
      GAP: begin
        if (g_cnt <= ONE) begin
          w_cnt_nx = w_sh;
          pulse_nx = 1'b1;
          state_nx = HIGH;
        end else begin
          g_cnt_nx = g_cnt - ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.pulse_out      = pulse_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err_zero_width = err_q;
endmodule

// File: doc/tg_pulse_gen.md
Name: tg_pulse_gen

Overview:
Test-generator pulse source that drives the DA_test pulse lines consumed by the TG assertion checker. On a start request it emits a train of high pulses on pulse_out. Each pulse is high for exactly `width` clk cycles and is followed by a programmable low gap. It sits directly upstream of the checker: pulse_out connects to DA_test1 and the width input to B_test1, so every pulse satisfies "rise, then fall exactly B_test1 cycles later".

Parameters:
- CNT_W, 4, bit width of the width, gap and count inputs and of their internal counters.

Ports:
- clk  input  1  system clock; all logic on posedge.
- C_rst  input  1  reset, synchronous, active-high.
- start  input  1  request a pulse train; sampled only in IDLE.
- width  input  CNT_W  high time per pulse, in clk cycles.
- gap  input  CNT_W  low time between pulses, in clk cycles.
- count  input  CNT_W  number of pulses in the train.
- pulse_out  output  1  registered pulse line (to DA_test1).
- busy  output  1  high while a train is in progress.
- done  output  1  one-cycle strobe at the end of a train.
- err_zero_width  output  1  one-cycle strobe when start is rejected because width==0.

Behaviour:
- Reset: C_rst high at a posedge forces state=IDLE on the next cycle and clears pulse_out, busy, done, err_zero_width and all counters to 0. Reset mid-train aborts the train at once: no done, no partial completion.
- All outputs are registered. No combinational path runs from inputs to outputs.
- FSM states: IDLE, HIGH, GAP.
- IDLE:
  - If start=1 and width!=0, latch width, gap and count into shadow registers and go to HIGH. pulse_out=1 from the next cycle.
  - If start=1 and width==0, stay in IDLE and pulse err_zero_width for one cycle. pulse_out stays 0. A zero-width pulse cannot satisfy the checker.
- Latency: start accepted at cycle t gives pulse_out=1 on cycles t+1 .. t+W and pulse_out=0 at t+W+1, where W is the latched width.
- HIGH:
  - The width counter is loaded with W on entry and decrements each cycle.
  - After W high cycles, if pulses remain, go to GAP. Otherwise go to IDLE.
- GAP:
  - pulse_out=0 for G cycles, where G = latched gap, and gap==0 is treated as 1. At least one low cycle is required so the next rising edge is visible.
  - Then return to HIGH.
- Pulse count: the counter loads count on accept and decrements at the end of each HIGH phase. count==0 is treated as 1.
- busy = 1 from the cycle pulse_out first rises (t+1) through the last high cycle. It is 0 in the cycle pulse_out falls after the final pulse.
- done = 1 for exactly that falling cycle (same cycle busy drops).
- A start in that same cycle is accepted (state is IDLE), which gives a minimum 1-cycle low between trains.
- start while busy is ignored entirely: shadow registers are unchanged and no error is flagged.
- Changes to width, gap or count while busy have no effect; only the values latched at accept are used.
- Arithmetic: counters are unsigned CNT_W bits. Maximum width is 2^CNT_W-1 = 15 cycles. No wrap-around is possible because counters stop at terminal value.
- Simultaneous C_rst and start: reset wins.

Test Plan:
1. Single pulse. width=5, count=1, start at cycle 10 -> pulse_out high cycles 11-15, low at 16; done=1 and busy=0 at 16; checker pass count +1.
2. Train. width=3, gap=2, count=3, start at cycle 0 -> pulse_out high 1-3, low 4-5, high 6-8, low 9-10, high 11-13, low 14; done only at 14.
3. Boundaries. width=15 (max) -> 15 high cycles. width=1, gap=0, count=2 -> high 1, low 2, high 3, low 4. width=0 -> err_zero_width for one cycle, pulse_out stays 0, busy stays 0.
4. Busy interactions. start re-asserted mid-train, and width changed from 4 to 9 mid-pulse -> the train is unaltered and the original width 4 is honoured. Back-to-back start in the done cycle -> next pulse rises one cycle after done.
5. Reset mid-pulse. Assert C_rst at the third high cycle of a width=8 pulse -> pulse_out=0, busy=0 the next cycle, no done. A new start after reset release runs normally.
6. Random regression. Random width 1-15, gap 0-15, count 0-15, start and C_rst -> zero checker failures, and the pulse count equals the checker pass count.
